mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the MMU: accepts byte/halfword/word requests from the core over a valid/ready handshake and drives the MMU's address, mode and data lines.
- Converts byte addresses to MMU word addresses and absorbs the MMU's registered read latency.
- Performs read-modify-write for sub-word stores and returns one response per request.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the MMU: word addressing, read latency, sub-word RMW.
// Optional MEM_ACCESS_STATS_EN adds saturating response counters.
module mem_access_unit #(
  parameter int unsigned READ_LATENCY       = 1,
  parameter logic [31:0] WORD_ADDRESS_LIMIT = 32'hff
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mmu_address,
  output logic        mmu_mode,
  output logic [31:0] mmu_wdata,
  input  logic [31:0] mmu_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errors
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]  state;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_lane;
  logic [31:0] lat_wdata;
  logic [2:0]  cnt;
  logic        bad;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      req_size == 2'd3:                         bad = 1'b1;
      req_size == 2'd1 && req_address[0]:       bad = 1'b1;
      req_size == 2'd2 && |req_address[1:0]:    bad = 1'b1;
      default:                                  bad = 1'b0;
    endcase
    if ({2'b00, req_address[31:2]} > WORD_ADDRESS_LIMIT)
      bad = 1'b1;
  end

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  ln,
    input logic        s
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {ln, 3'b000});
    h = ln[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      sz == 2'd0: extract = {{24{s & b[7]}}, b};
      sz == 2'd1: extract = {{16{s & h[15]}}, h};
      default:    extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  ln,
    input logic [31:0] d
  );
    merge = w;
    if (sz == 2'd0)
      merge[{ln, 3'b000} +: 8] = d[7:0];
    else
      merge[{ln[1], 4'b0000} +: 16] = d[15:0];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      mmu_address <= '0;
      mmu_mode    <= 1'b0;
      mmu_wdata   <= '0;
      lat_write   <= 1'b0;
      lat_size    <= '0;
      lat_signed  <= 1'b0;
      lat_lane    <= '0;
      lat_wdata   <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_lane   <= req_address[1:0];
            lat_wdata  <= req_wdata;
            cnt        <= '0;
            req_ready  <= 1'b0;
            if (bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mmu_address <= {2'b00, req_address[31:2]};
              if (req_write && req_size == 2'd2) begin
                state     <= WRITE;
                mmu_mode  <= 1'b1;
                mmu_wdata <= req_wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (cnt == 3'(READ_LATENCY)) begin
            if (lat_write) begin
              state     <= WRITE;
              mmu_mode  <= 1'b1;
              mmu_wdata <= merge(mmu_rdata, lat_size, lat_lane, lat_wdata);
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= extract(mmu_rdata, lat_size, lat_lane, lat_signed);
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: begin
          mmu_mode   <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic done;
  assign done = (state == RESP) && resp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else if (done) begin
      if (resp_error) begin
        if (stat_errors != 16'hffff) stat_errors <= stat_errors + 16'd1;
      end else if (lat_write) begin
        if (stat_stores != 16'hffff) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != 16'hffff) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle registered MMU model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mmu_address;
  logic        mmu_mode;
  logic [31:0] mmu_wdata;
  logic [31:0] mmu_rdata;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errors;
`endif

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [256];
  int          wr_cnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  mem_access_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mmu_address (mmu_address),
    .mmu_mode    (mmu_mode),
    .mmu_wdata   (mmu_wdata),
    .mmu_rdata   (mmu_rdata)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errors (stat_errors)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mmu_mode) mem[mmu_address[7:0]] <= mmu_wdata;
    mmu_rdata <= mem[mmu_address[7:0]];
  end

  always @(negedge clock) begin
    if (mmu_mode) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = mmu_address;
      wr_data = mmu_wdata;
    end
  end

  task automatic do_req(
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    wr_cnt = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_signed = s; req_address = a; req_wdata = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_error;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++;
    if ({req_ready, resp_valid, resp_error, mmu_mode} !== 4'b1000)
      $display("FAIL reset_ctrl got %b want 1000",
               {req_ready, resp_valid, resp_error, mmu_mode});
    else passed++;
    total++;
    if (resp_rdata !== 32'h0 || mmu_address !== 32'h0 || mmu_wdata !== 32'h0)
      $display("FAIL reset_data got %h %h %h want zeros",
               resp_rdata, mmu_address, mmu_wdata);
    else passed++;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 2'd2, 1'b0, 32'h140, 32'hDEADBEEF, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0)
      $display("FAIL word_store_resp got lat=%0d err=%b rd=%h want 2 0 0", lat, er, rd);
    else passed++;
    total++;
    if (wr_cnt !== 1 || wr_addr !== 32'h50 || wr_data !== 32'hDEADBEEF)
      $display("FAIL word_store_mmu got n=%0d a=%h d=%h want 1 50 deadbeef",
               wr_cnt, wr_addr, wr_data);
    else passed++;
    do_req(1'b0, 2'd2, 1'b0, 32'h140, 32'h0, rd, er, lat);
    total++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF || wr_cnt !== 0)
      $display("FAIL word_load got lat=%0d err=%b rd=%h n=%0d want 3 0 deadbeef 0",
               lat, er, rd, wr_cnt);
    else passed++;
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat;
    mem[8'h50] = 32'h11223344;
    do_req(1'b1, 2'd0, 1'b0, 32'h141, 32'h000000AA, rd, er, lat);
    total++;
    if (lat !== 4 || er !== 1'b0 || rd !== 32'h0)
      $display("FAIL byte_store_resp got lat=%0d err=%b rd=%h want 4 0 0", lat, er, rd);
    else passed++;
    total++;
    if (wr_cnt !== 1 || wr_addr !== 32'h50 || wr_data !== 32'h1122AA44)
      $display("FAIL byte_store_mmu got n=%0d a=%h d=%h want 1 50 1122aa44",
               wr_cnt, wr_addr, wr_data);
    else passed++;
    do_req(1'b0, 2'd0, 1'b1, 32'h141, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFFFFAA || er !== 1'b0)
      $display("FAIL byte_load_signed got %h want ffffffaa", rd);
    else passed++;
    do_req(1'b0, 2'd0, 1'b0, 32'h141, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h000000AA)
      $display("FAIL byte_load_unsigned got %h want 000000aa", rd);
    else passed++;
    do_req(1'b0, 2'd0, 1'b0, 32'h143, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h00000011)
      $display("FAIL byte_load_lane3 got %h want 00000011", rd);
    else passed++;
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int lat;
    mem[8'h50] = 32'h80010000;
    do_req(1'b0, 2'd1, 1'b1, 32'h142, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0)
      $display("FAIL half_load_signed got %h want ffff8001", rd);
    else passed++;
    do_req(1'b0, 2'd1, 1'b0, 32'h142, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h00008001)
      $display("FAIL half_load_unsigned got %h want 00008001", rd);
    else passed++;
    do_req(1'b1, 2'd1, 1'b0, 32'h140, 32'h0000BEEF, rd, er, lat);
    total++;
    if (wr_cnt !== 1 || wr_data !== 32'h8001BEEF || lat !== 4)
      $display("FAIL half_store_low got n=%0d d=%h lat=%0d want 1 8001beef 4",
               wr_cnt, wr_data, lat);
    else passed++;
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs[0] = 32'h141; sizes[0] = 2'd2;
    addrs[1] = 32'h140; sizes[1] = 2'd3;
    addrs[2] = 32'h400; sizes[2] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF, rd, er, lat);
      total++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || wr_cnt !== 0)
        $display("FAIL error_%0d got err=%b rd=%h lat=%0d n=%0d want 1 0 1 0",
                 i, er, rd, lat, wr_cnt);
      else passed++;
    end
    mem[8'hFF] = 32'h12345678;
    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'h12345678)
      $display("FAIL limit_word got err=%b rd=%h want 0 12345678", er, rd);
    else passed++;
  endtask

  task automatic test_backpressure;
    logic [31:0] first;
    int lat;
    bit ok;
    mem[8'h20] = 32'hCAFEF00D;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
    req_signed = 1'b0; req_address = 32'h80;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    first = resp_rdata;
    ok = (first === 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0)
        ok = 1'b0;
    end
    total++;
    if (!ok)
      $display("FAIL hold_stable got v=%b rd=%h rr=%b want 1 cafef00d 0",
               resp_valid, resp_rdata, req_ready);
    else passed++;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL hold_release got v=%b rr=%b want 0 1", resp_valid, req_ready);
    else passed++;
  endtask

`ifdef MEM_ACCESS_STATS_EN
  task automatic test_stats;
    total++;
    if (stat_loads !== 16'd8 || stat_stores !== 16'd3 || stat_errors !== 16'd3)
      $display("FAIL stats got %0d %0d %0d want 8 3 3",
               stat_loads, stat_stores, stat_errors);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid;
    mem[8'h50] = 32'h11223344;
    wr_cnt = 0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
    req_signed = 1'b0; req_address = 32'h141; req_wdata = 32'h55;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({req_ready, resp_valid, resp_error, mmu_mode} !== 4'b1000 ||
        mmu_address !== 32'h0 || mmu_wdata !== 32'h0 || resp_rdata !== 32'h0)
      $display("FAIL mid_reset_outputs got %b %h %h %h",
               {req_ready, resp_valid, resp_error, mmu_mode},
               mmu_address, mmu_wdata, resp_rdata);
    else passed++;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    total++;
    if (req_ready !== 1'b1 || wr_cnt !== 0 || mem[8'h50] !== 32'h11223344)
      $display("FAIL mid_reset_after got rr=%b n=%0d mem=%h want 1 0 11223344",
               req_ready, wr_cnt, mem[8'h50]);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    wr_cnt = 0; wr_addr = 32'h0; wr_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
`ifdef MEM_ACCESS_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
